// File: rtl/j_dac_fifo_if.sv
// DSP-bus side of the audio DAC frame FIFO. The bus master drives the strobes
// and the DAC block returns its samples, serial stream and status.
interface j_dac_fifo_if #(
    parameter int NCH   = 2,
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW  = $clog2(DEPTH) + 1;

    logic                 dacw;
    logic [CHW-1:0]       dch;
    logic [WIDTH-1:0]     dspd;
    logic                 ts;
    logic                 clr;
    logic [NCH*WIDTH-1:0] dac_out;
    logic                 sdo;
    logic                 sfs;
    logic                 sact;
    logic [LW-1:0]        level;
    logic                 tint;
    logic                 underrun;
    logic                 overflow;
    logic                 slip;

    modport master (
        output dacw, dch, dspd, ts, clr,
        input  dac_out, sdo, sfs, sact, level, tint, underrun, overflow, slip
    );

    modport slave (
        input  dacw, dch, dspd, ts, clr,
        output dac_out, sdo, sfs, sact, level, tint, underrun, overflow, slip
    );
endinterface

// File: rtl/j_dac_fifo.sv
// N-channel audio DAC block: staged channel writes commit whole frames into a
// FIFO; each sample tick pops one frame to the parallel outputs and a serial shifter.
module j_dac_fifo #(
    parameter int NCH   = 2,
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int LWM   = 2
) (
    input  logic       clk,
    input  logic       reset,
    j_dac_fifo_if.slave bus
);
    localparam int FW = NCH * WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FW + 1);

    logic [WIDTH-1:0] stage_q [NCH];
    logic [WIDTH-1:0] stage_d [NCH];
    logic [FW-1:0]    mem_q   [DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d, level;
    logic [FW-1:0]    dac_q, dac_d, shift_q, shift_d, frame_in, head;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             und_q, und_d, ovf_q, ovf_d, slip_q, slip_d;
    logic             wr_ok, commit, empty, full, pop, push, busy;

    // Reorders a frame so channel 0 sits in the MSBs; shifting left then
    // emits channel 0 first, each channel MSB first.
    function automatic logic [FW-1:0] serialize(input logic [FW-1:0] f);
        logic [FW-1:0] r;
        r = '0;
        for (int unsigned c = 0; c < NCH; c++)
            r[FW-1-c*WIDTH -: WIDTH] = f[c*WIDTH +: WIDTH];
        return r;
    endfunction

    assign wr_ok  = 32'(bus.dch) < NCH;
    assign commit = bus.dacw && (32'(bus.dch) == NCH - 1);
    assign level  = wptr_q - rptr_q;
    assign empty  = (level == '0);
    assign full   = (level == (AW+1)'(DEPTH));
    assign pop    = bus.ts && !empty;
    assign push   = commit && (!full || pop);
    assign head   = mem_q[rptr_q[AW-1:0]];
    assign busy   = (cnt_q != '0);

    always_comb begin
        frame_in = '0;
        for (int unsigned c = 0; c < NCH; c++)
            frame_in[c*WIDTH +: WIDTH] = (c == NCH - 1) ? bus.dspd : stage_q[c];
    end

    always_comb begin
        stage_d = stage_q;
        if (bus.dacw && wr_ok)
            stage_d[bus.dch] = bus.dspd;

        wptr_d = wptr_q + (AW+1)'(push);
        rptr_d = rptr_q + (AW+1)'(pop);
        dac_d  = pop ? head : dac_q;

        shift_d = shift_q;
        cnt_d   = cnt_q;
        // A tick always restarts the frame; on empty the held samples repeat.
        if (bus.ts) begin
            shift_d = serialize(pop ? head : dac_q);
            cnt_d   = CW'(FW);
        end else if (busy) begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - 1'b1;
        end

        und_d  = (und_q  && !bus.clr) || (bus.ts && empty);
        ovf_d  = (ovf_q  && !bus.clr) || (commit && full && !pop);
        slip_d = (slip_q && !bus.clr) || (bus.ts && busy);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            dac_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            und_q   <= 1'b0;
            ovf_q   <= 1'b0;
            slip_q  <= 1'b0;
        end else begin
            stage_q <= stage_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            dac_q   <= dac_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            und_q   <= und_d;
            ovf_q   <= ovf_d;
            slip_q  <= slip_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q[AW-1:0]] <= frame_in;
    end

    assign bus.dac_out  = dac_q;
    assign bus.sact     = busy;
    assign bus.sdo      = busy & shift_q[FW-1];
    assign bus.sfs      = (cnt_q == CW'(FW));
    assign bus.level    = level;
    assign bus.tint     = (level <= (AW+1)'(LWM));
    assign bus.underrun = und_q;
    assign bus.overflow = ovf_q;
    assign bus.slip     = slip_q;
endmodule

// File: tb/tb_j_dac_fifo.sv
// Directed bench for j_dac_fifo: a queue-based frame model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_j_dac_fifo;
    localparam int NCH   = 2;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int LWM   = 2;
    localparam int FW    = NCH * WIDTH;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    j_dac_fifo_if #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    j_dac_fifo_if #(.NCH(3), .WIDTH(8), .DEPTH(4)) bus2 ();

    j_dac_fifo #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH), .LWM(LWM)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    j_dac_fifo #(.NCH(3), .WIDTH(8), .DEPTH(4), .LWM(1)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a queue of frames, the last shown frame, and an index into the serial bit stream.
    logic [FW-1:0]    mq[$];
    logic [WIDTH-1:0] mstage [NCH];
    logic [FW-1:0]    mdac = '0;
    logic [FW-1:0]    mser = '0;
    int               midx = FW;
    bit               mund = 0, movf = 0, mslip = 0;

    always @(posedge clk or posedge reset) begin : model
        logic [FW-1:0] fin;
        bit            act;
        if (reset) begin
            mq.delete();
            for (int c = 0; c < NCH; c++) mstage[c] = '0;
            mdac = '0; mser = '0; midx = FW;
            mund = 0; movf = 0; mslip = 0;
        end else begin
            act = (midx < FW);
            for (int c = 0; c < NCH; c++)
                fin[c*WIDTH +: WIDTH] = (c == NCH - 1) ? bus.dspd : mstage[c];
            if (bus.clr) begin mund = 0; movf = 0; mslip = 0; end
            if (bus.ts) begin
                if (mq.size() > 0) mdac = mq.pop_front();
                else mund = 1;
                if (act) mslip = 1;
                mser = mdac;
                midx = 0;
            end else if (act) begin
                midx++;
            end
            if (bus.dacw && int'(bus.dch) == NCH - 1) begin
                if (mq.size() < DEPTH) mq.push_back(fin);
                else movf = 1;
            end
            if (bus.dacw && int'(bus.dch) < NCH) mstage[bus.dch] = bus.dspd;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_sdo;
            exp_sdo = (midx < FW) ? mser[(midx / WIDTH) * WIDTH + WIDTH - 1 - (midx % WIDTH)] : 1'b0;
            chk("dac_out",  64'(bus.dac_out),  64'(mdac));
            chk("sdo",      64'(bus.sdo),      64'(exp_sdo));
            chk("sfs",      64'(bus.sfs),      64'(midx == 0));
            chk("sact",     64'(bus.sact),     64'(midx < FW));
            chk("level",    64'(bus.level),    64'(mq.size()));
            chk("tint",     64'(bus.tint),     64'(mq.size() <= LWM));
            chk("underrun", 64'(bus.underrun), 64'(mund));
            chk("overflow", 64'(bus.overflow), 64'(movf));
            chk("slip",     64'(bus.slip),     64'(mslip));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [0:0] ch, input logic [WIDTH-1:0] d);
        bus.dacw = 1'b1; bus.dch = ch; bus.dspd = d;
        step();
        bus.dacw = 1'b0;
    endtask

    task automatic wr2(input logic [1:0] ch, input logic [7:0] d);
        bus2.dacw = 1'b1; bus2.dch = ch; bus2.dspd = d;
        step();
        bus2.dacw = 1'b0;
    endtask

    task automatic pulse_ts();
        bus.ts = 1'b1;
        step();
        bus.ts = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cap;
        bus.dacw = 0; bus.dch = '0; bus.dspd = '0; bus.ts = 0; bus.clr = 0;
        bus2.dacw = 0; bus2.dch = '0; bus2.dspd = '0; bus2.ts = 0; bus2.clr = 0;
        #12 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_level", 64'(bus.level), 64'd0);
        chk("rst_tint",  64'(bus.tint),  64'd1);
        chk("rst_dac",   64'(bus.dac_out), 64'd0);
        reset = 1'b0;
        idle(2);

        // Basic frame and serial stream
        wr(1'b0, 16'h1234);
        chk("t1_level0", 64'(bus.level), 64'd0);
        wr(1'b1, 16'hABCD);
        chk("t1_level1", 64'(bus.level), 64'd1);
        pulse_ts();
        chk("t1_level_pop", 64'(bus.level), 64'd0);
        chk("t1_dac", 64'(bus.dac_out), 64'hABCD1234);
        cap = '0;
        for (int i = 0; i < 32; i++) begin
            if (i == 0) chk("t1_sfs_first", 64'(bus.sfs), 64'd1);
            if (i == 1) chk("t1_sfs_second", 64'(bus.sfs), 64'd0);
            cap = {cap[30:0], bus.sdo};
            step();
        end
        chk("t1_stream", 64'(cap), 64'h1234ABCD);
        chk("t1_sact_end", 64'(bus.sact), 64'd0);

        // Overflow: DEPTH+1 commits, then pop in order
        for (int k = 0; k <= DEPTH; k++) begin
            wr(1'b0, 16'h1000 + 16'(k));
            wr(1'b1, 16'h2000 + 16'(k));
        end
        chk("t2_level_full", 64'(bus.level), 64'(DEPTH));
        chk("t2_overflow", 64'(bus.overflow), 64'd1);
        for (int k = 0; k < DEPTH; k++) begin
            pulse_ts();
            chk("t2_pop_order", 64'(bus.dac_out), 64'({16'h2000 + 16'(k), 16'h1000 + 16'(k)}));
            idle(1);
        end
        chk("t2_level_empty", 64'(bus.level), 64'd0);
        pulse_clr();
        chk("t2_ovf_clr", 64'(bus.overflow), 64'd0);

        // Underrun re-sends the last frame
        pulse_ts();
        chk("t3_underrun", 64'(bus.underrun), 64'd1);
        chk("t3_dac_hold", 64'(bus.dac_out), 64'h20071007);
        idle(33);
        chk("t3_sact_end", 64'(bus.sact), 64'd0);
        pulse_clr();
        chk("t3_und_clr", 64'(bus.underrun), 64'd0);

        // Commit and tick together at empty and at full
        bus.dacw = 1; bus.dch = 1'b1; bus.dspd = 16'h5555; bus.ts = 1;
        step();
        bus.dacw = 0; bus.ts = 0;
        chk("t4_level_1", 64'(bus.level), 64'd1);
        chk("t4_underrun", 64'(bus.underrun), 64'd1);
        pulse_clr();
        for (int k = 0; k < DEPTH - 1; k++) wr(1'b1, 16'h6000 + 16'(k));
        chk("t4_level_full", 64'(bus.level), 64'(DEPTH));
        idle(40);
        bus.dacw = 1; bus.dch = 1'b1; bus.dspd = 16'h7777; bus.ts = 1;
        step();
        bus.dacw = 0; bus.ts = 0;
        chk("t4_level_stay", 64'(bus.level), 64'(DEPTH));
        chk("t4_no_ovf", 64'(bus.overflow), 64'd0);

        // Slip: retick mid-shift
        pulse_clr();
        idle(40);
        chk("t5_slip0", 64'(bus.slip), 64'd0);
        pulse_ts();
        idle(9);
        pulse_ts();
        chk("t5_slip", 64'(bus.slip), 64'd1);
        chk("t5_sfs", 64'(bus.sfs), 64'd1);
        idle(34);
        chk("t5_sact_end", 64'(bus.sact), 64'd0);

        // Low-water mark
        for (int k = 0; k < DEPTH - 2; k++) begin
            pulse_ts();
            idle(1);
        end
        chk("t6_drained", 64'(bus.level), 64'd0);
        for (int k = 0; k < 3; k++) wr(1'b1, 16'h8000 + 16'(k));
        chk("t6_tint_lvl3", 64'(bus.tint), 64'd0);
        pulse_ts();
        chk("t6_level2", 64'(bus.level), 64'd2);
        chk("t6_tint_lvl2", 64'(bus.tint), 64'd1);

        // Out-of-range channel on a 3-channel instance
        wr2(2'd0, 8'h11);
        wr2(2'd1, 8'h22);
        wr2(2'd3, 8'h99);
        chk("t8_dch3_nocommit", 64'(bus2.level), 64'd0);
        wr2(2'd2, 8'h33);
        chk("t8_commit", 64'(bus2.level), 64'd1);
        bus2.ts = 1; step(); bus2.ts = 0;
        chk("t8_frame", 64'(bus2.dac_out), 64'h332211);

        // Reset mid-shift
        idle(5);
        chk("t7_sact_pre", 64'(bus.sact), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("t7_dac",  64'(bus.dac_out), 64'd0);
        chk("t7_sdo",  64'(bus.sdo), 64'd0);
        chk("t7_sfs",  64'(bus.sfs), 64'd0);
        chk("t7_sact", 64'(bus.sact), 64'd0);
        chk("t7_level", 64'(bus.level), 64'd0);
        chk("t7_tint", 64'(bus.tint), 64'd1);
        chk("t7_flags", 64'({bus.underrun, bus.overflow, bus.slip}), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        idle(3);
        chk("t7_post_level", 64'(bus.level), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
